// File: rtl/sync_ram_dp_pkg.sv
// Shared types, constants and helpers for the simple-dual-port RAM family.
package ram_pkg;

    // Widest word the merge helper handles; callers zero-extend and truncate.
    localparam int MAX_DATA_W = 1024;

    typedef logic [0:0] state_t;
    localparam state_t ST_INIT = 1'b0;
    localparam state_t ST_RUN  = 1'b1;

    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

    function automatic logic [MAX_DATA_W-1:0] be_merge(
        input logic [MAX_DATA_W-1:0]   old_w,
        input logic [MAX_DATA_W-1:0]   new_w,
        input logic [MAX_DATA_W/8-1:0] be
    );
        logic [MAX_DATA_W-1:0] res;
        res = old_w;
        for (int k = 0; k < MAX_DATA_W / 8; k++) begin
            if (be[k]) res[8*k +: 8] = new_w[8*k +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/sync_ram_dp_if.sv
// Request/response bundle between a bus-side master and the RAM.
interface sync_ram_dp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
);
    logic                init_done;
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_W-1:0]   wr_data;
    logic [DATA_W/8-1:0] wr_be;
    logic                rd_en;
    logic [ADDR_W-1:0]   rd_addr;
    logic                rd_valid;
    logic [DATA_W-1:0]   rd_data;
    logic                rd_err;

    modport master (
        input  init_done, rd_valid, rd_data, rd_err,
        output wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr
    );

    modport slave (
        output init_done, rd_valid, rd_data, rd_err,
        input  wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr
    );
endinterface

// File: rtl/sync_ram_dp_init_ctrl.sv
// Post-reset clear sequencer: walks every word once, then reports ready.
module sram_init_ctrl
    import ram_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    output logic             o_init_done,
    output logic             o_clr_en,
    output logic [IDX_W-1:0] o_clr_addr
);

    state_t           r_state;
    logic [IDX_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_INIT;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    if (r_cnt == IDX_W'(DEPTH - 1)) begin
                        r_state <= ST_RUN;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_init_done = (r_state == ST_RUN);
    assign o_clr_en    = (r_state == ST_INIT) && !rst;
    assign o_clr_addr  = r_cnt;

endmodule

// File: rtl/sync_ram_dp.sv
// Simple-dual-port synchronous RAM with byte enables, selectable read latency,
// read-during-write policy and a hardware clear after reset.
module sync_ram_dp
    import ram_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 8,
    parameter int DEPTH      = 256,
    parameter int RD_LATENCY = 1,
    parameter int RDW_MODE   = RDW_OLD
) (
    input logic          clk,
    input logic          rst,
    sync_ram_dp_if.slave ram
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
        $error("sync_ram_dp: RD_LATENCY must be 1 or 2");
    end
    if (DATA_W % 8 != 0 || DATA_W > MAX_DATA_W) begin : g_bad_width
        $error("sync_ram_dp: DATA_W must be a multiple of 8 and fit the merge helper");
    end
    if (DEPTH < 1 || DEPTH > 2 ** ADDR_W) begin : g_bad_depth
        $error("sync_ram_dp: DEPTH must be in 1..2**ADDR_W");
    end

    logic              w_init_done;
    logic              w_clr_en;
    logic [IDX_W-1:0]  w_clr_addr;

    sram_init_ctrl #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_init_ctrl (
        .clk         (clk),
        .rst         (rst),
        .o_init_done (w_init_done),
        .o_clr_en    (w_clr_en),
        .o_clr_addr  (w_clr_addr)
    );

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_wr_in, w_rd_in, w_wr_ok, w_rd_ok, w_bypass;
    logic [IDX_W-1:0]  w_wr_idx, w_rd_idx;
    logic [DATA_W-1:0] w_wr_new, w_rd_word;

    assign w_wr_in  = ({1'b0, ram.wr_addr} < (ADDR_W + 1)'(DEPTH));
    assign w_rd_in  = ({1'b0, ram.rd_addr} < (ADDR_W + 1)'(DEPTH));
    assign w_wr_idx = ram.wr_addr[IDX_W-1:0];
    assign w_rd_idx = ram.rd_addr[IDX_W-1:0];
    // Requests are only honoured in run state and never on a reset edge.
    assign w_wr_ok  = w_init_done && !rst && ram.wr_en && w_wr_in;
    assign w_rd_ok  = w_init_done && !rst && ram.rd_en;

    assign w_wr_new = DATA_W'(be_merge(MAX_DATA_W'(r_mem[w_wr_idx]),
                                       MAX_DATA_W'(ram.wr_data),
                                       (MAX_DATA_W / 8)'(ram.wr_be)));

    assign w_bypass  = (RDW_MODE == RDW_NEW) && w_wr_ok && (ram.wr_addr == ram.rd_addr);
    assign w_rd_word = w_bypass ? w_wr_new : r_mem[w_rd_idx];

    always_ff @(posedge clk) begin
        if (w_clr_en) begin
            r_mem[w_clr_addr] <= '0;
        end else if (w_wr_ok) begin
            r_mem[w_wr_idx] <= w_wr_new;
        end
    end

    logic              r_rd_valid1, r_rd_err1;
    logic [DATA_W-1:0] r_rd_data1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_valid1 <= 1'b0;
            r_rd_err1   <= 1'b0;
            r_rd_data1  <= '0;
        end else begin
            r_rd_valid1 <= w_rd_ok;
            if (w_rd_ok) begin
                r_rd_err1  <= !w_rd_in;
                r_rd_data1 <= w_rd_in ? w_rd_word : '0;
            end
        end
    end

    if (RD_LATENCY == 2) begin : g_lat2
        logic              r_rd_valid2, r_rd_err2;
        logic [DATA_W-1:0] r_rd_data2;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_rd_valid2 <= 1'b0;
                r_rd_err2   <= 1'b0;
                r_rd_data2  <= '0;
            end else begin
                r_rd_valid2 <= r_rd_valid1;
                if (r_rd_valid1) begin
                    r_rd_err2  <= r_rd_err1;
                    r_rd_data2 <= r_rd_data1;
                end
            end
        end

        assign ram.rd_valid = r_rd_valid2;
        assign ram.rd_err   = r_rd_err2;
        assign ram.rd_data  = r_rd_data2;
    end else begin : g_lat1
        assign ram.rd_valid = r_rd_valid1;
        assign ram.rd_err   = r_rd_err1;
        assign ram.rd_data  = r_rd_data1;
    end

    assign ram.init_done = w_init_done;

endmodule

// File: tb/tb_sync_ram_dp.sv
// Directed bench: three RAM instances (lat1/old, lat2/new, depth-200 lat1/old) share stimulus.
module tb_sync_ram_dp;
    import ram_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        wr_en, rd_en;
    logic [7:0]  wr_addr, rd_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;

    int n_tests = 0;
    int n_fail  = 0;

    sync_ram_dp_if #(.DATA_W(32), .ADDR_W(8)) if_a ();
    sync_ram_dp_if #(.DATA_W(32), .ADDR_W(8)) if_b ();
    sync_ram_dp_if #(.DATA_W(32), .ADDR_W(8)) if_c ();

    assign if_a.wr_en = wr_en;  assign if_b.wr_en = wr_en;  assign if_c.wr_en = wr_en;
    assign if_a.wr_addr = wr_addr;  assign if_b.wr_addr = wr_addr;  assign if_c.wr_addr = wr_addr;
    assign if_a.wr_data = wr_data;  assign if_b.wr_data = wr_data;  assign if_c.wr_data = wr_data;
    assign if_a.wr_be = wr_be;  assign if_b.wr_be = wr_be;  assign if_c.wr_be = wr_be;
    assign if_a.rd_en = rd_en;  assign if_b.rd_en = rd_en;  assign if_c.rd_en = rd_en;
    assign if_a.rd_addr = rd_addr;  assign if_b.rd_addr = rd_addr;  assign if_c.rd_addr = rd_addr;

    sync_ram_dp #(.DATA_W(32), .ADDR_W(8), .DEPTH(256), .RD_LATENCY(1), .RDW_MODE(RDW_OLD))
        u_a (.clk(clk), .rst(rst), .ram(if_a));
    sync_ram_dp #(.DATA_W(32), .ADDR_W(8), .DEPTH(256), .RD_LATENCY(2), .RDW_MODE(RDW_NEW))
        u_b (.clk(clk), .rst(rst), .ram(if_b));
    sync_ram_dp #(.DATA_W(32), .ADDR_W(8), .DEPTH(200), .RD_LATENCY(1), .RDW_MODE(RDW_OLD))
        u_c (.clk(clk), .rst(rst), .ram(if_c));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
        rd_en = 1'b0; rd_addr = '0;
    endtask

    task automatic test_reset();
        int na, nb, nc;
        idle();
        rst = 1'b1;
        repeat (3) tick();
        n_tests++;
        if ({if_a.init_done, if_b.init_done, if_c.init_done} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_init_done: got %b expected 000",
                     {if_a.init_done, if_b.init_done, if_c.init_done});
        end
        n_tests++;
        if ({if_a.rd_valid, if_b.rd_valid, if_c.rd_valid, if_a.rd_err, if_b.rd_err, if_c.rd_err}
            !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_valid_err: got %b expected 000000",
                     {if_a.rd_valid, if_b.rd_valid, if_c.rd_valid,
                      if_a.rd_err, if_b.rd_err, if_c.rd_err});
        end
        n_tests++;
        if ({if_a.rd_data, if_b.rd_data, if_c.rd_data} !== 96'h0) begin
            n_fail++;
            $display("FAIL reset_rd_data: got %h expected 0",
                     {if_a.rd_data, if_b.rd_data, if_c.rd_data});
        end
        rst = 1'b0;
        na = 0; nb = 0; nc = 0;
        for (int e = 1; e <= 300; e++) begin
            tick();
            if (if_a.init_done && na == 0) na = e;
            if (if_b.init_done && nb == 0) nb = e;
            if (if_c.init_done && nc == 0) nc = e;
            if (na != 0 && nb != 0 && nc != 0) break;
        end
        n_tests++;
        if (na != 256 || nb != 256 || nc != 200) begin
            n_fail++;
            $display("FAIL clear_edges: got a=%0d b=%0d c=%0d expected 256 256 200", na, nb, nc);
        end
        // First request accepted is on the edge right after init_done rises.
        rd_en = 1'b1; rd_addr = 8'h37;
        tick();
        idle();
        n_tests++;
        if ({if_a.rd_valid, if_a.rd_err, if_a.rd_data, if_c.rd_valid, if_c.rd_err, if_c.rd_data,
             if_b.rd_valid} !== {1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL cleared_read_lat1: got a=%b/%b/%h c=%b/%b/%h b_valid=%b expected 1/0/0",
                     if_a.rd_valid, if_a.rd_err, if_a.rd_data,
                     if_c.rd_valid, if_c.rd_err, if_c.rd_data, if_b.rd_valid);
        end
        tick();
        n_tests++;
        if ({if_b.rd_valid, if_b.rd_err, if_b.rd_data, if_a.rd_valid}
            !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL cleared_read_lat2: got b=%b/%b/%h a_valid=%b expected 1/0/0 a_valid=0",
                     if_b.rd_valid, if_b.rd_err, if_b.rd_data, if_a.rd_valid);
        end
    endtask

    task automatic test_byte_enables();
        wr_en = 1'b1; wr_addr = 8'h10; wr_data = 32'hAABBCCDD; wr_be = 4'hF;
        tick();
        wr_data = 32'h11223344; wr_be = 4'b0101;
        tick();
        idle();
        rd_en = 1'b1; rd_addr = 8'h10;
        tick();
        idle();
        n_tests++;
        if ({if_a.rd_valid, if_a.rd_data, if_c.rd_data, if_b.rd_valid}
            !== {1'b1, 32'hAA22CC44, 32'hAA22CC44, 1'b0}) begin
            n_fail++;
            $display("FAIL be_lat1: got a=%b/%h c=%h b_valid=%b expected 1/aa22cc44 b_valid=0",
                     if_a.rd_valid, if_a.rd_data, if_c.rd_data, if_b.rd_valid);
        end
        tick();
        n_tests++;
        if ({if_b.rd_valid, if_b.rd_data, if_a.rd_valid, if_a.rd_data}
            !== {1'b1, 32'hAA22CC44, 1'b0, 32'hAA22CC44}) begin
            n_fail++;
            $display("FAIL be_lat2_hold: got b=%b/%h a=%b/%h expected 1/aa22cc44 0/aa22cc44",
                     if_b.rd_valid, if_b.rd_data, if_a.rd_valid, if_a.rd_data);
        end
    endtask

    task automatic test_rdw();
        wr_en = 1'b1; wr_addr = 8'h05; wr_data = 32'hDEADBEEF; wr_be = 4'hF;
        rd_en = 1'b1; rd_addr = 8'h05;
        tick();
        wr_addr = 8'h06; wr_data = 32'h11223344; wr_be = 4'b0011; rd_addr = 8'h06;
        n_tests++;
        if ({if_a.rd_valid, if_a.rd_data, if_c.rd_data} !== {1'b1, 32'h0, 32'h0}) begin
            n_fail++;
            $display("FAIL rdw_old_full: got a=%b/%h c=%h expected 1/00000000",
                     if_a.rd_valid, if_a.rd_data, if_c.rd_data);
        end
        tick();
        idle();
        n_tests++;
        if ({if_b.rd_valid, if_b.rd_data, if_a.rd_data} !== {1'b1, 32'hDEADBEEF, 32'h0}) begin
            n_fail++;
            $display("FAIL rdw_new_full: got b=%b/%h a=%h expected 1/deadbeef a=0",
                     if_b.rd_valid, if_b.rd_data, if_a.rd_data);
        end
        tick();
        n_tests++;
        if ({if_b.rd_valid, if_b.rd_data} !== {1'b1, 32'h00003344}) begin
            n_fail++;
            $display("FAIL rdw_new_partial: got %b/%h expected 1/00003344",
                     if_b.rd_valid, if_b.rd_data);
        end
        rd_en = 1'b1; rd_addr = 8'h05;
        tick();
        rd_addr = 8'h06;
        n_tests++;
        if (if_a.rd_data !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL rdw_after_5: got %h expected deadbeef", if_a.rd_data);
        end
        tick();
        idle();
        n_tests++;
        if ({if_a.rd_data, if_b.rd_data} !== {32'h00003344, 32'hDEADBEEF}) begin
            n_fail++;
            $display("FAIL rdw_after_6: got a=%h b=%h expected 00003344 deadbeef",
                     if_a.rd_data, if_b.rd_data);
        end
    endtask

    task automatic test_out_of_range();
        wr_en = 1'b1; wr_be = 4'hF; wr_addr = 8'd10; wr_data = 32'hCAFEF00D;
        tick();
        wr_addr = 8'd210; wr_data = 32'h12345678;
        tick();
        wr_addr = 8'd10; wr_data = 32'hFFFFFFFF; wr_be = 4'h0;
        tick();
        idle();
        rd_en = 1'b1; rd_addr = 8'd210;
        tick();
        rd_addr = 8'd10;
        n_tests++;
        if ({if_c.rd_valid, if_c.rd_err, if_c.rd_data, if_a.rd_valid, if_a.rd_err, if_a.rd_data}
            !== {1'b1, 1'b1, 32'h0, 1'b1, 1'b0, 32'h12345678}) begin
            n_fail++;
            $display("FAIL oor_read: got c=%b/%b/%h a=%b/%b/%h expected c=1/1/0 a=1/0/12345678",
                     if_c.rd_valid, if_c.rd_err, if_c.rd_data,
                     if_a.rd_valid, if_a.rd_err, if_a.rd_data);
        end
        tick();
        idle();
        n_tests++;
        if ({if_c.rd_err, if_c.rd_data, if_a.rd_data, if_b.rd_err, if_b.rd_data}
            !== {1'b0, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 32'h12345678}) begin
            n_fail++;
            $display("FAIL oor_alias_be0: got c=%b/%h a=%h b=%b/%h expected 0/cafef00d 0/12345678",
                     if_c.rd_err, if_c.rd_data, if_a.rd_data, if_b.rd_err, if_b.rd_data);
        end
        tick();
        n_tests++;
        if ({if_c.rd_valid, if_c.rd_data, if_b.rd_valid, if_b.rd_data}
            !== {1'b0, 32'hCAFEF00D, 1'b1, 32'hCAFEF00D}) begin
            n_fail++;
            $display("FAIL oor_hold: got c=%b/%h b=%b/%h expected c=0/cafef00d b=1/cafef00d",
                     if_c.rd_valid, if_c.rd_data, if_b.rd_valid, if_b.rd_data);
        end
    endtask

    task automatic test_back_to_back();
        int bad_a, bad_b;
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_be = 4'hF; wr_addr = 8'(i); wr_data = 32'(i + 1);
            tick();
        end
        idle();
        bad_a = 0; bad_b = 0;
        for (int k = 0; k < 18; k++) begin
            rd_en = (k < 16); rd_addr = 8'(k);
            tick();
            if (if_a.rd_valid !== (k < 16) || (k < 16 && if_a.rd_data !== 32'(k + 1))) begin
                bad_a++;
                $display("FAIL stream_lat1[%0d]: got %b/%h expected %b/%h",
                         k, if_a.rd_valid, if_a.rd_data, (k < 16), 32'(k + 1));
            end
            if (if_b.rd_valid !== (k >= 1 && k <= 16) ||
                (k >= 1 && k <= 16 && if_b.rd_data !== 32'(k))) begin
                bad_b++;
                $display("FAIL stream_lat2[%0d]: got %b/%h expected %b/%h",
                         k, if_b.rd_valid, if_b.rd_data, (k >= 1 && k <= 16), 32'(k));
            end
        end
        idle();
        n_tests += 2;
        if (bad_a != 0) n_fail++;
        if (bad_b != 0) n_fail++;
    endtask

    task automatic test_reset_mid_stream();
        int bad, done;
        wr_en = 1'b1; wr_be = 4'hF; wr_addr = 8'h20; wr_data = 32'h5A5A5A5A;
        tick();
        idle();
        rd_en = 1'b1; rd_addr = 8'h20;
        tick();
        n_tests++;
        if ({if_a.rd_valid, if_a.rd_data} !== {1'b1, 32'h5A5A5A5A}) begin
            n_fail++;
            $display("FAIL mid_prewrite: got %b/%h expected 1/5a5a5a5a",
                     if_a.rd_valid, if_a.rd_data);
        end
        rd_addr = 8'h00;
        tick();
        rd_addr = 8'h01;
        tick();
        // Two reads are now inside the latency-2 pipe.
        idle();
        rst = 1'b1;
        tick();
        n_tests++;
        if ({if_a.rd_valid, if_b.rd_valid, if_c.rd_valid, if_a.init_done, if_b.init_done,
             if_c.init_done, if_b.rd_data} !== {6'b0, 32'h0}) begin
            n_fail++;
            $display("FAIL mid_reset_edge: got valid=%b%b%b done=%b%b%b b_data=%h expected 0",
                     if_a.rd_valid, if_b.rd_valid, if_c.rd_valid,
                     if_a.init_done, if_b.init_done, if_c.init_done, if_b.rd_data);
        end
        rst = 1'b0;
        // Requests held high through the clear must be ignored.
        wr_en = 1'b1; wr_be = 4'hF; wr_addr = 8'h30; wr_data = 32'h00000077;
        rd_en = 1'b1; rd_addr = 8'h30;
        bad = 0; done = 0;
        for (int e = 1; e <= 300; e++) begin
            tick();
            if (if_a.rd_valid !== 1'b0 || if_b.rd_valid !== 1'b0) bad++;
            if (if_a.init_done) begin
                done = e;
                break;
            end
        end
        idle();
        n_tests++;
        if (bad != 0 || done != 256) begin
            n_fail++;
            $display("FAIL mid_reclear: got stray_valid=%0d done_edge=%0d expected 0 256",
                     bad, done);
        end
        rd_en = 1'b1; rd_addr = 8'h20;
        tick();
        rd_addr = 8'h30;
        n_tests++;
        if ({if_a.rd_valid, if_a.rd_data} !== {1'b1, 32'h0}) begin
            n_fail++;
            $display("FAIL mid_word20: got %b/%h expected 1/00000000",
                     if_a.rd_valid, if_a.rd_data);
        end
        tick();
        idle();
        n_tests++;
        if ({if_a.rd_data, if_b.rd_valid, if_b.rd_data} !== {32'h0, 1'b1, 32'h0}) begin
            n_fail++;
            $display("FAIL mid_word30_a_word20_b: got a=%h b=%b/%h expected 0 1/0",
                     if_a.rd_data, if_b.rd_valid, if_b.rd_data);
        end
        tick();
        n_tests++;
        if ({if_b.rd_valid, if_b.rd_data} !== {1'b1, 32'h0}) begin
            n_fail++;
            $display("FAIL mid_word30_b: got %b/%h expected 1/00000000",
                     if_b.rd_valid, if_b.rd_data);
        end
    endtask

    initial begin
        idle();
        rst = 1'b1;
        test_reset();
        test_byte_enables();
        test_rdw();
        test_out_of_range();
        test_back_to_back();
        test_reset_mid_stream();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
